// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU tile sequencer: the sequencer FSM state
// encoding and the default geometry used by the sequencer, its address
// generator and the core-facing interface.
package tpu_pkg;

  // BRAM word-address width.
  localparam int AWIDTH_DEF = 10;

  localparam int DIM_WIDTH_DEF   = 8;  // width of each tile-count field
  localparam int TILE_STRIDE_DEF = 4;  // BRAM words per tile (MAT_MUL_SIZE)

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/tpu_tile_sequencer_if.sv
// Handshake/bus between the tile sequencer and the matmul core.
//   core_start      sequencer -> core  one-cycle launch of a tile op
//   core_done       core -> sequencer  tile op complete
//   core_addr_a/b/c sequencer -> core  BRAM tile addresses of the op
//   core_accumulate sequencer -> core  add into the existing partial sum
//   core_store      sequencer -> core  last k step, write the tile to C
// master = sequencer side, slave = core side.
interface tpu_tile_sequencer_if
  import tpu_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF
) ();

  logic              core_start;
  logic              core_done;
  logic [AWIDTH-1:0] core_addr_a;
  logic [AWIDTH-1:0] core_addr_b;
  logic [AWIDTH-1:0] core_addr_c;
  logic              core_accumulate;
  logic              core_store;

  modport master (
    output core_start,
    output core_addr_a,
    output core_addr_b,
    output core_addr_c,
    output core_accumulate,
    output core_store,
    input  core_done
  );

  modport slave (
    input  core_start,
    input  core_addr_a,
    input  core_addr_b,
    input  core_addr_c,
    input  core_accumulate,
    input  core_store,
    output core_done
  );

endinterface

// File: rtl/tpu_tile_addr_gen.sv
// Tile address generator: m/n/k loop counters (m outer, n middle, k inner)
// and running BRAM pointers for A, B and C built from adders only.
//   clk, resetn          clock, synchronous active-low reset
//   init                 latch dims/bases and point at tile (0,0,0)
//   step                 advance to the next (m,n,k)
//   num_m/num_n/num_k    tile counts (sampled on init)
//   base_a/base_b/base_c BRAM bases (sampled on init)
//   addr_a/addr_b/addr_c registered tile addresses of the current op
//   accumulate, store    registered flags: k != 0, k == K-1
//   last_k               current k is the final inner step
//   last_tile            current (m,n) is the final output tile
module tpu_tile_addr_gen
  import tpu_pkg::*;
#(
  parameter int AWIDTH      = AWIDTH_DEF,
  parameter int DIM_WIDTH   = DIM_WIDTH_DEF,
  parameter int TILE_STRIDE = TILE_STRIDE_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 init,
  input  logic                 step,
  input  logic [DIM_WIDTH-1:0] num_m,
  input  logic [DIM_WIDTH-1:0] num_n,
  input  logic [DIM_WIDTH-1:0] num_k,
  input  logic [AWIDTH-1:0]    base_a,
  input  logic [AWIDTH-1:0]    base_b,
  input  logic [AWIDTH-1:0]    base_c,
  output logic [AWIDTH-1:0]    addr_a,
  output logic [AWIDTH-1:0]    addr_b,
  output logic [AWIDTH-1:0]    addr_c,
  output logic                 accumulate,
  output logic                 store,
  output logic                 last_k,
  output logic                 last_tile
);

  localparam logic [AWIDTH-1:0]    STRIDE = AWIDTH'(TILE_STRIDE);
  localparam logic [DIM_WIDTH-1:0] ONE    = DIM_WIDTH'(1);

  logic [DIM_WIDTH-1:0] dim_m_q, dim_m_d, dim_n_q, dim_n_d, dim_k_q, dim_k_d;
  logic [DIM_WIDTH-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
  logic [AWIDTH-1:0]    a_row_q, a_row_d, a_ptr_q, a_ptr_d;
  logic [AWIDTH-1:0]    b_ptr_q, b_ptr_d, b_base_q, b_base_d, c_ptr_q, c_ptr_d;
  logic                 acc_q, acc_d, store_q, store_d;
  logic                 last_n, last_m;

  assign last_k    = (k_q == dim_k_q - ONE);
  assign last_n    = (n_q == dim_n_q - ONE);
  assign last_m    = (m_q == dim_m_q - ONE);
  assign last_tile = last_n && last_m;

  always_comb begin
    dim_m_d  = dim_m_q;
    dim_n_d  = dim_n_q;
    dim_k_d  = dim_k_q;
    m_d      = m_q;
    n_d      = n_q;
    k_d      = k_q;
    a_row_d  = a_row_q;
    a_ptr_d  = a_ptr_q;
    b_ptr_d  = b_ptr_q;
    b_base_d = b_base_q;
    c_ptr_d  = c_ptr_q;
    acc_d    = acc_q;
    store_d  = store_q;
    if (init) begin
      dim_m_d  = num_m;
      dim_n_d  = num_n;
      dim_k_d  = num_k;
      m_d      = '0;
      n_d      = '0;
      k_d      = '0;
      a_row_d  = base_a;
      a_ptr_d  = base_a;
      b_ptr_d  = base_b;
      b_base_d = base_b;
      c_ptr_d  = base_c;
      acc_d    = 1'b0;
      store_d  = (num_k == ONE);
    end else if (step) begin
      if (!last_k) begin
        k_d     = k_q + ONE;
        a_ptr_d = a_ptr_q + STRIDE;
        b_ptr_d = b_ptr_q + STRIDE;
      end else if (!last_n) begin
        // Same A row again for the next column; B simply keeps walking.
        k_d     = '0;
        n_d     = n_q + ONE;
        a_ptr_d = a_row_q;
        b_ptr_d = b_ptr_q + STRIDE;
        c_ptr_d = c_ptr_q + STRIDE;
      end else begin
        // The next A row starts right after the last tile of this row,
        // so a_ptr + STRIDE is exactly row_base + K*STRIDE.
        k_d     = '0;
        n_d     = '0;
        m_d     = m_q + ONE;
        a_ptr_d = a_ptr_q + STRIDE;
        a_row_d = a_ptr_q + STRIDE;
        b_ptr_d = b_base_q;
        c_ptr_d = c_ptr_q + STRIDE;
      end
      acc_d   = (k_d != '0);
      store_d = (k_d == dim_k_q - ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dim_m_q  <= '0;
      dim_n_q  <= '0;
      dim_k_q  <= '0;
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      a_row_q  <= '0;
      a_ptr_q  <= '0;
      b_ptr_q  <= '0;
      b_base_q <= '0;
      c_ptr_q  <= '0;
      acc_q    <= 1'b0;
      store_q  <= 1'b0;
    end else begin
      dim_m_q  <= dim_m_d;
      dim_n_q  <= dim_n_d;
      dim_k_q  <= dim_k_d;
      m_q      <= m_d;
      n_q      <= n_d;
      k_q      <= k_d;
      a_row_q  <= a_row_d;
      a_ptr_q  <= a_ptr_d;
      b_ptr_q  <= b_ptr_d;
      b_base_q <= b_base_d;
      c_ptr_q  <= c_ptr_d;
      acc_q    <= acc_d;
      store_q  <= store_d;
    end
  end

  assign addr_a     = a_ptr_q;
  assign addr_b     = b_ptr_q;
  assign addr_c     = c_ptr_q;
  assign accumulate = acc_q;
  assign store      = store_q;

endmodule

// File: rtl/tpu_tile_sequencer.sv
// Tile sequencer: walks the matmul core over an M x N x K grid of tiles,
// issuing one core op per (m,n,k) and waiting for completion in between.
//   clk, resetn        clock, synchronous active-low reset
//   start              one-cycle run request (ignored while busy)
//   abort              level; stop once the in-flight tile completes
//   num_tiles_m/n/k    tile counts of the run
//   base_a/b/c         BRAM bases of A, B and C
//   core               master side of the core handshake/bus
//   busy               run in progress
//   done               run finished (sticky until the next valid start)
//   err_zero_dim       last start had a zero tile count
//   aborted            last run was stopped by abort
//   tiles_issued       core_start pulses in the current/last run
module tpu_tile_sequencer
  import tpu_pkg::*;
#(
  parameter int AWIDTH      = AWIDTH_DEF,
  parameter int DIM_WIDTH   = DIM_WIDTH_DEF,
  parameter int TILE_STRIDE = TILE_STRIDE_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIM_WIDTH-1:0] num_tiles_m,
  input  logic [DIM_WIDTH-1:0] num_tiles_n,
  input  logic [DIM_WIDTH-1:0] num_tiles_k,
  input  logic [AWIDTH-1:0]    base_a,
  input  logic [AWIDTH-1:0]    base_b,
  input  logic [AWIDTH-1:0]    base_c,
  tpu_tile_sequencer_if.master core,
  output logic                 busy,
  output logic                 done,
  output logic                 err_zero_dim,
  output logic                 aborted,
  output logic [15:0]          tiles_issued
);

  seq_state_e        state_q, state_d;
  logic [15:0]       tiles_q, tiles_d;
  logic              err_q, err_d;
  logic              aborted_q, aborted_d;
  logic              ag_init, ag_step, ag_last_k, ag_last_tile;
  logic              zero_dim;
  logic [AWIDTH-1:0] ag_addr_a, ag_addr_b, ag_addr_c;
  logic              ag_acc, ag_store;

  assign zero_dim = (num_tiles_m == '0) || (num_tiles_n == '0) ||
                    (num_tiles_k == '0);

  tpu_tile_addr_gen #(
    .AWIDTH      (AWIDTH),
    .DIM_WIDTH   (DIM_WIDTH),
    .TILE_STRIDE (TILE_STRIDE)
  ) u_addr_gen (
    .clk        (clk),
    .resetn     (resetn),
    .init       (ag_init),
    .step       (ag_step),
    .num_m      (num_tiles_m),
    .num_n      (num_tiles_n),
    .num_k      (num_tiles_k),
    .base_a     (base_a),
    .base_b     (base_b),
    .base_c     (base_c),
    .addr_a     (ag_addr_a),
    .addr_b     (ag_addr_b),
    .addr_c     (ag_addr_c),
    .accumulate (ag_acc),
    .store      (ag_store),
    .last_k     (ag_last_k),
    .last_tile  (ag_last_tile)
  );

  always_comb begin
    state_d   = state_q;
    tiles_d   = tiles_q;
    err_d     = err_q;
    aborted_d = aborted_q;
    ag_init   = 1'b0;
    ag_step   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (zero_dim) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            ag_init   = 1'b1;
            tiles_d   = '0;
            err_d     = 1'b0;
            aborted_d = 1'b0;
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        tiles_d = tiles_q + 16'd1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core.core_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        // Addresses only advance when another op follows, so the final
        // op's addresses remain visible after the run.
        if ((ag_last_k && ag_last_tile) || abort) begin
          state_d = ST_DONE;
          if (abort) aborted_d = 1'b1;
        end else begin
          ag_step = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      tiles_q   <= '0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tiles_q   <= tiles_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  assign core.core_start      = (state_q == ST_ISSUE);
  assign core.core_addr_a     = ag_addr_a;
  assign core.core_addr_b     = ag_addr_b;
  assign core.core_addr_c     = ag_addr_c;
  assign core.core_accumulate = ag_acc;
  assign core.core_store      = ag_store;

  assign busy         = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                        (state_q == ST_NEXT);
  assign done         = (state_q == ST_DONE);
  assign err_zero_dim = err_q;
  assign aborted      = aborted_q;
  assign tiles_issued = tiles_q;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Directed bench for tpu_tile_sequencer: single tile, 2x2x2 sweep, zero
// dimension, abort mid-run, start while busy and reset mid-run.
module tb_tpu_tile_sequencer;
  import tpu_pkg::*;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          resetn, start, abort;
  logic [DW-1:0] nm, nn, nk;
  logic [AW-1:0] ba, bb, bc;
  logic          busy, done, err_zero_dim, aborted;
  logic [15:0]   tiles_issued;

  always #5 clk = ~clk;

  tpu_tile_sequencer_if #(.AWIDTH(AW)) core_if ();

  tpu_tile_sequencer #(.AWIDTH(AW), .DIM_WIDTH(DW), .TILE_STRIDE(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .abort        (abort),
    .num_tiles_m  (nm),
    .num_tiles_n  (nn),
    .num_tiles_k  (nk),
    .base_a       (ba),
    .base_b       (bb),
    .base_c       (bc),
    .core         (core_if.master),
    .busy         (busy),
    .done         (done),
    .err_zero_dim (err_zero_dim),
    .aborted      (aborted),
    .tiles_issued (tiles_issued)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int n_starts = 0;
  int starts_ref;

  // Expected 2x2x2 sequence with base_a=0, base_b=0x40, base_c=0x80.
  logic [AW-1:0] exp_a [8] = '{10'h000, 10'h004, 10'h000, 10'h004,
                               10'h008, 10'h00C, 10'h008, 10'h00C};
  logic [AW-1:0] exp_b [8] = '{10'h040, 10'h044, 10'h048, 10'h04C,
                               10'h040, 10'h044, 10'h048, 10'h04C};
  logic [AW-1:0] exp_c [8] = '{10'h080, 10'h080, 10'h084, 10'h084,
                               10'h088, 10'h088, 10'h08C, 10'h08C};
  logic          exp_acc [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic          exp_st  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  always @(negedge clk) if (core_if.core_start === 1'b1) n_starts++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for core_start, check the op, then return core_done
  // after dly cycles in WAIT. Returns just after core_done was sampled.
  task automatic issue_and_complete(input string tag, input int idx,
                                    input logic [AW-1:0] ea, input logic [AW-1:0] eb,
                                    input logic [AW-1:0] ec, input logic eacc,
                                    input logic est, input int dly);
    int cyc;
    cyc = 0;
    while (core_if.core_start !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check($sformatf("%s_seen_%0d", tag, idx), 32'(core_if.core_start), 32'd1);
    check($sformatf("%s_a_%0d", tag, idx), 32'(core_if.core_addr_a), 32'(ea));
    check($sformatf("%s_b_%0d", tag, idx), 32'(core_if.core_addr_b), 32'(eb));
    check($sformatf("%s_c_%0d", tag, idx), 32'(core_if.core_addr_c), 32'(ec));
    check($sformatf("%s_acc_%0d", tag, idx), 32'(core_if.core_accumulate), 32'(eacc));
    check($sformatf("%s_store_%0d", tag, idx), 32'(core_if.core_store), 32'(est));
    tick();
    check($sformatf("%s_pulse_%0d", tag, idx), 32'(core_if.core_start), 32'd0);
    check($sformatf("%s_hold_a_%0d", tag, idx), 32'(core_if.core_addr_a), 32'(ea));
    repeat (dly) tick();
    core_if.core_done = 1'b1;
    tick();
    core_if.core_done = 1'b0;
  endtask

  task automatic run_2x2x2(input string tag);
    for (int i = 0; i < 8; i++)
      issue_and_complete(tag, i, exp_a[i], exp_b[i], exp_c[i], exp_acc[i], exp_st[i], i % 3);
    tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_tiles"}, 32'(tiles_issued), 32'd8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; core_if.core_done = 1'b0;
    nm = '0; nn = '0; nk = '0; ba = '0; bb = '0; bc = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_zero_dim), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_tiles", 32'(tiles_issued), 32'd0);
    check("rst_core_start", 32'(core_if.core_start), 32'd0);
    check("rst_addrs", {2'b0, core_if.core_addr_a, core_if.core_addr_b, core_if.core_addr_c}, 32'd0);
    check("rst_flags", {30'd0, core_if.core_accumulate, core_if.core_store}, 32'd0);
    resetn = 1'b1;
    tick();

    // Single tile.
    nm = 8'd1; nn = 8'd1; nk = 8'd1; ba = 10'h008; bb = 10'h000; bc = 10'h020;
    starts_ref = n_starts;
    pulse_start();
    check("t1_latency", 32'(core_if.core_start), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    issue_and_complete("t1", 0, 10'h008, 10'h000, 10'h020, 1'b0, 1'b1, 1);
    check("t1_done_early", 32'(done), 32'd0);
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_tiles", 32'(tiles_issued), 32'd1);
    tick();
    check("t1_start_count", 32'(n_starts - starts_ref), 32'd1);

    // 2x2x2 sweep; config scrambled after start must not matter.
    nm = 8'd2; nn = 8'd2; nk = 8'd2; ba = 10'h000; bb = 10'h040; bc = 10'h080;
    starts_ref = n_starts;
    pulse_start();
    nm = 8'd1; nk = 8'd5; ba = 10'h3F0; bb = 10'h111; bc = 10'h222;
    run_2x2x2("sweep");
    tick();
    check("sweep_start_count", 32'(n_starts - starts_ref), 32'd8);

    // Zero inner dimension.
    nm = 8'd2; nn = 8'd2; nk = 8'd0;
    starts_ref = n_starts;
    pulse_start();
    tick();
    check("zero_done", 32'(done), 32'd1);
    check("zero_err", 32'(err_zero_dim), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_start_count", 32'(n_starts - starts_ref), 32'd0);

    // Abort during the third WAIT.
    nk = 8'd2; ba = 10'h000; bb = 10'h040; bc = 10'h080;
    starts_ref = n_starts;
    pulse_start();
    check("abort_err_cleared", 32'(err_zero_dim), 32'd0);
    issue_and_complete("ab", 0, exp_a[0], exp_b[0], exp_c[0], exp_acc[0], exp_st[0], 0);
    issue_and_complete("ab", 1, exp_a[1], exp_b[1], exp_c[1], exp_acc[1], exp_st[1], 0);
    tick();
    check("ab_third_start", 32'(core_if.core_start), 32'd1);
    check("ab_third_b", 32'(core_if.core_addr_b), 32'h048);
    tick();
    abort = 1'b1;
    tick();
    check("ab_still_busy", 32'(busy), 32'd1);
    core_if.core_done = 1'b1;
    tick();
    core_if.core_done = 1'b0;
    tick();
    abort = 1'b0;
    check("ab_done", 32'(done), 32'd1);
    check("ab_aborted", 32'(aborted), 32'd1);
    check("ab_tiles", 32'(tiles_issued), 32'd3);
    repeat (3) tick();
    check("ab_start_count", 32'(n_starts - starts_ref), 32'd3);

    // start while busy is ignored; reset mid-run clears everything.
    pulse_start();
    check("rerun_aborted_cleared", 32'(aborted), 32'd0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_ignored", 32'(core_if.core_start), 32'd0);
    check("busy_start_tiles", 32'(tiles_issued), 32'd1);
    check("busy_start_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_addrs", {2'b0, core_if.core_addr_a, core_if.core_addr_b, core_if.core_addr_c}, 32'd0);
    check("midrst_tiles", 32'(tiles_issued), 32'd0);
    tick();
    pulse_start();
    run_2x2x2("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
